// File: rtl/io_pkg.sv
// Shared UART state encoding and framing constants for the serial I/O port.
// Imported by io_uart_rx and io_uart_port.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/io_uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer plus RX FSM.
// Emits the received byte with a one-cycle rx_valid on a good stop bit.
module io_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);
  import io_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    TOPB = 3'(UART_DATA_BITS - 1);

  logic          s1;
  logic          rxs;
  logic          rxs_d;
  logic          fall;
  logic          tick_mid;
  logic          tick_bit;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  uart_state_t   state;
  uart_state_t   state_nx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= UART_IDLE_LEVEL;
      rxs   <= UART_IDLE_LEVEL;
      rxs_d <= UART_IDLE_LEVEL;
    end else begin
      s1    <= serial;
      rxs   <= s1;
      rxs_d <= rxs;
    end
  end

  assign fall     = rxs_d & ~rxs;
  assign tick_mid = (cnt == MID);
  assign tick_bit = (cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rx_valid = 1'b0;
    case (state)
      IDLE:  if (fall) state_nx = START;
      START: if (tick_mid) state_nx = rxs ? IDLE : DATA;
      DATA:  if (tick_bit && idx == TOPB) state_nx = STOP;
      STOP: begin
        if (tick_bit) state_nx = IDLE;
        rx_valid = tick_bit & rxs;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
      sh  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
        end
        START: cnt <= tick_mid ? '0 : cnt + 1'b1;
        DATA: begin
          if (tick_bit) begin
            cnt <= '0;
            idx <= idx + 3'd1;
            sh  <= {rxs, sh[7:1]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP:    cnt <= tick_bit ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  assign rx_byte = sh;

endmodule

// File: rtl/io_uart_port.sv
// Serial I/O port: FGI/INPR input flags, OUTR transmitter, 8N1 UART.
// Define IO_LOOPBACK_EN to feed the receiver from tx_o instead of rx_i.
module io_uart_port #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_i,
  output logic       tx_o,
  input  logic       OUTR_load,
  input  logic [7:0] OUTR_data,
  input  logic       INP_ack,
  output logic       FGI,
  output logic       FGO,
  output logic [7:0] INPR,
  output logic       rx_overrun
);
  import io_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    TOPB = 3'(UART_DATA_BITS - 1);

  logic          rx_src;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          tick;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  uart_state_t   state;
  uart_state_t   state_nx;

`ifdef IO_LOOPBACK_EN
  logic unused_rx_i;
  assign unused_rx_i = rx_i;
  assign rx_src      = tx_o;
`else
  assign rx_src = rx_i;
`endif

  io_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock   (clock),
    .reset_n (reset_n),
    .serial  (rx_src),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid)
  );

  // A frame landing with the ack hands over the new byte and keeps FGI set
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      FGI        <= 1'b0;
      INPR       <= '0;
      rx_overrun <= 1'b0;
    end else if (rx_valid && INP_ack) begin
      FGI        <= 1'b1;
      INPR       <= rx_byte;
      rx_overrun <= 1'b0;
    end else if (INP_ack) begin
      FGI        <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (rx_valid) begin
      if (FGI) begin
        rx_overrun <= 1'b1;
      end else begin
        FGI  <= 1'b1;
        INPR <= rx_byte;
      end
    end
  end

  assign FGO  = (state == IDLE);
  assign tick = (cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_o     = UART_IDLE_LEVEL;
    case (state)
      IDLE: if (OUTR_load) state_nx = START;
      START: begin
        tx_o = ~UART_IDLE_LEVEL;
        if (tick) state_nx = DATA;
      end
      DATA: begin
        tx_o = sh[0];
        if (tick && idx == TOPB) state_nx = STOP;
      end
      STOP:    if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
      sh  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (OUTR_load && FGO) sh <= OUTR_data;
        end
        DATA: begin
          if (tick) begin
            cnt <= '0;
            idx <= idx + 3'd1;
            sh  <= {1'b0, sh[7:1]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        START, STOP: cnt <= tick ? '0 : cnt + 1'b1;
        default:     cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_port.sv
// Directed bench for io_uart_port: RX frame table, TX waveform, corners.
// Define IO_LOOPBACK_EN to run the loopback case instead of the rx_i cases.
module tb_io_uart_port;
  localparam int C = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx_i;
  logic       tx_o;
  logic       OUTR_load;
  logic [7:0] OUTR_data;
  logic       INP_ack;
  logic       FGI;
  logic       FGO;
  logic [7:0] INPR;
  logic       rx_overrun;

  int checks  = 0;
  int errors  = 0;
  int ncyc    = 0;
  int ack_at  = -1;
  int rise_at = -1;

  typedef struct {
    logic       ack;
    logic [7:0] data;
    logic       stop;
    logic       fgi;
    logic [7:0] inpr;
    logic       ovr;
  } rx_vec_t;

  rx_vec_t vt[7];

  io_uart_port #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_i      (rx_i),
    .tx_o      (tx_o),
    .OUTR_load (OUTR_load),
    .OUTR_data (OUTR_data),
    .INP_ack   (INP_ack),
    .FGI       (FGI),
    .FGO       (FGO),
    .INPR      (INPR),
    .rx_overrun(rx_overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    ncyc++;
    if (FGI && rise_at < 0) rise_at = ncyc;
    INP_ack = (ncyc == ack_at);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic ack();
    INP_ack = 1'b1;
    step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_i    = 1'b0;
    ncyc    = 0;
    rise_at = -1;
    steps(C);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      steps(C);
    end
    rx_i = stop;
    steps(C);
    rx_i = 1'b1;
    steps(2 * C);
  endtask

  task automatic load(input logic [7:0] d);
    OUTR_data = d;
    OUTR_load = 1'b1;
    step();
    OUTR_load = 1'b0;
  endtask

  initial begin
    logic [9:0] bits;
    logic [9:0] bad;
    logic       fgo_bad;

    vt[0] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b0};
    vt[1] = '{1'b0, 8'h22, 1'b1, 1'b1, 8'h11, 1'b1};
    vt[2] = '{1'b1, 8'h7E, 1'b0, 1'b0, 8'h11, 1'b0};
    vt[3] = '{1'b0, 8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
    vt[4] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vt[5] = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vt[6] = '{1'b0, 8'h55, 1'b1, 1'b1, 8'hFF, 1'b1};

    reset_n   = 1'b0;
    rx_i      = 1'b1;
    OUTR_load = 1'b0;
    OUTR_data = '0;
    INP_ack   = 1'b0;
    steps(3);
    reset_n = 1'b1;
    step();
    chk("rst tx_o", tx_o, 1);
    chk("rst FGO", FGO, 1);
    chk("rst FGI", FGI, 0);
    chk("rst INPR", INPR, 0);
    chk("rst ovr", rx_overrun, 0);

`ifndef IO_LOOPBACK_EN
    send_frame(8'hA5, 1'b1);
    chk("rx latency", rise_at, 2 + C / 2 + 9 * C + 1);
    chk("rx A5 INPR", INPR, 8'hA5);
    chk("rx A5 FGI", FGI, 1);
    ack();
    chk("ack FGI", FGI, 0);

    for (int v = 0; v < 7; v++) begin
      if (vt[v].ack) begin
        ack();
        chk($sformatf("v%0d ack FGI", v), FGI, 0);
        chk($sformatf("v%0d ack ovr", v), rx_overrun, 0);
      end
      send_frame(vt[v].data, vt[v].stop);
      chk($sformatf("v%0d FGI", v), FGI, vt[v].fgi);
      chk($sformatf("v%0d INPR", v), INPR, vt[v].inpr);
      chk($sformatf("v%0d ovr", v), rx_overrun, vt[v].ovr);
    end

    ack_at = 2 + C / 2 + 9 * C;
    send_frame(8'h66, 1'b1);
    ack_at = -1;
    chk("same-cycle FGI", FGI, 1);
    chk("same-cycle INPR", INPR, 8'h66);
    chk("same-cycle ovr", rx_overrun, 0);

    ack();
    rx_i = 1'b0;
    step();
    rx_i = 1'b1;
    steps(3 * C);
    chk("glitch FGI", FGI, 0);
    send_frame(8'hC3, 1'b1);
    chk("post-glitch FGI", FGI, 1);
    chk("post-glitch INPR", INPR, 8'hC3);
`endif

    bits    = {1'b1, 8'h3C, 1'b0};
    bad     = '0;
    fgo_bad = 1'b0;
    load(8'h3C);
    for (int t = 1; t <= 10 * C; t++) begin
      if (tx_o !== bits[(t - 1) / C]) bad[(t - 1) / C] = 1'b1;
      if (FGO !== 1'b0) fgo_bad = 1'b1;
      OUTR_load = (t == 49);
      OUTR_data = (t == 49) ? 8'hFF : 8'h3C;
      step();
    end
    for (int k = 0; k < 10; k++)
      chk($sformatf("tx bit%0d wrong", k), bad[k], 0);
    chk("tx FGO low in frame", fgo_bad, 0);
    chk("tx FGO end", FGO, 1);
    chk("tx idle end", tx_o, 1);

    load(8'h00);
    steps(40);
    chk("mid-tx low", tx_o, 0);
    reset_n = 1'b0;
    #1;
    chk("async rst tx_o", tx_o, 1);
    chk("async rst FGO", FGO, 1);
    steps(2);
    reset_n = 1'b1;
    steps(2);
    chk("post rst FGO", FGO, 1);
    chk("post rst FGI", FGI, 0);

`ifdef IO_LOOPBACK_EN
    load(8'h5A);
    steps(10 * C + 20);
    chk("loop INPR", INPR, 8'h5A);
    chk("loop FGI", FGI, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_uart_port.md
# io_uart_port

Serial I/O port for the basic computer: it supplies the FGI/INPR input path that feeds the controller's interrupt and INP logic, and it consumes the controller's OUTR_load strobe to transmit a byte. The port contains an 8N1 UART receiver and an 8N1 UART transmitter, each built as an independent state machine. It sits between the controller/AC datapath and the external serial pins.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal values are ≥ 4 and even.
- clock  in  1  system clock; all flops are rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_i  in  1  serial receive pin; idles high.
- tx_o  out  1  serial transmit pin; idles high.
- OUTR_load  in  1  one-cycle strobe from the controller; loads OUTR_data and starts transmission.
- OUTR_data  in  8  AC[7:0], the byte to transmit.
- INP_ack  in  1  one-cycle strobe on INP execution; clears FGI.
- FGI  out  1  input flag: INPR holds an unread byte.
- FGO  out  1  output flag: the transmitter is ready to accept a byte.
- INPR  out  8  received byte.
- rx_overrun  out  1  sticky flag: a byte was dropped because FGI was already set.

## Operation
- Values after reset: tx_o=1, FGO=1, FGI=0, INPR=0, rx_overrun=0, and both state machines in IDLE.
- RX path:
  - rx_i passes through a 2-flop synchronizer; the receiver works on the synchronized signal rxs.
  - RX states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a falling edge on rxs moves to START and clears the bit counter.
  - START: at count CLKS_PER_BIT/2, if rxs=0 go to DATA; if rxs=1 (false start) go to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, shifting 8 bits LSB first, then go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If rxs=1 the frame is valid; if rxs=0 it is a framing error, the byte is discarded and flags are unchanged. Either way return to IDLE.
  - Valid frame with FGI=0: INPR ← byte and FGI ← 1.
  - Valid frame with FGI=1: INPR is kept, the new byte is dropped, and rx_overrun ← 1.
  - INP_ack clears both FGI and rx_overrun.
  - Valid frame completing in the same cycle as INP_ack: INPR ← new byte, FGI stays 1, rx_overrun ← 0.
- TX path:
  - TX states: IDLE → START → DATA → STOP → IDLE.
  - OUTR_load while FGO=1: latch OUTR_data into the shift register, set FGO ← 0, go to START.
  - OUTR_load while FGO=0 is ignored; the byte in flight is not corrupted.
  - tx_o drives 0 in START, the data bits LSB first in DATA, and 1 in STOP. Each bit lasts CLKS_PER_BIT cycles.
  - FGO ← 1 at the end of STOP.
- Bit counters are $clog2(CLKS_PER_BIT) bits wide and wrap to 0 at every bit boundary. Bit index counters are 3 bits wide.
- Reset asserted mid-frame aborts both paths immediately: tx_o returns high and no partial byte is delivered.

## Timing
- RX:
  - Latency from the rx_i start-bit falling edge to FGI high is 2 (synchronizer) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles.
  - FGI is registered and rises one cycle after the stop-bit sample.
- INP_ack in cycle n: FGI=0 in cycle n+1.
- TX:
  - OUTR_load in cycle n: FGO=0 and tx_o=0 in cycle n+1.
  - tx_o returns to 1 (stop bit) at n+1+9·CLKS_PER_BIT.
  - FGO=1 at n+1+10·CLKS_PER_BIT, when tx_o is already idle.
- RX and TX run fully concurrently; neither stalls the other.

## Configuration
- IO_LOOPBACK_EN:
  - Defined: the receiver input is tx_o instead of rx_i; rx_i is ignored and tx_o still drives the pin.
  - Undefined: the receiver uses rx_i.

## Structure
- Package io_pkg holds:
  - the state enum uart_state_t {IDLE, START, DATA, STOP}, shared by RX and TX;
  - the constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1.
- Sub-module io_uart_rx contains the synchronizer and the RX FSM and outputs a byte plus a one-cycle rx_valid.
- The top level holds the FGI, INPR and rx_overrun flag logic, the TX FSM, and the loopback mux.

## Test plan
- Receive 0xA5 at CLKS_PER_BIT=16: FGI rises 2+8+144+1 cycles after the falling edge, INPR=0xA5; INP_ack then gives FGI=0 on the next cycle.
- OUTR_load with OUTR_data=0x3C: tx_o shows 0, then 0,0,1,1,1,1,0,0, then 1, each bit 16 cycles; FGO returns to 1 after 160 cycles. A second OUTR_load at cycle +50 is ignored.
- Two frames 0x11 then 0x22 with no INP_ack: INPR=0x11, FGI=1, rx_overrun=1. INP_ack then clears both.
- 1-cycle low glitch on rx_i: no FGI; RX is back in IDLE after the START check.
- Stop bit forced to 0 on byte 0x7E: FGI stays 0 and INPR is unchanged.
- reset_n pulsed low mid-TX: tx_o=1 and FGO=1 immediately. With IO_LOOPBACK_EN defined, OUTR_load 0x5A yields INPR=0x5A and FGI=1.
